// File: rtl/hex_scan_controller.sv
// Multiplexed 7-segment hex display scanner with guard slots between digits,
// leading-zero suppression and a frame-aligned double-buffered load port.
module hex_decoder (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'b1111111;
    unique case (nib_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end
endmodule

module hex_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  input  logic                    lzs_en,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [6:0]              seg_out,
  output logic                    frame_done
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GUARD} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [VAL_W-1:0]    active_q, active_d, pending_q, pending_d;
  logic                pending_valid_q, pending_valid_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [6:0]          seg_q, seg_d;
  logic                frame_done_q, frame_done_d;

  logic                tick, boundary, accept, commit, blanked;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [3:0]          nib;
  logic [6:0]          dec_seg;

  assign tick = enable && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!enable || cnt_q == CNT_LAST) cnt_d = '0;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    boundary = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (tick) begin
          state_d = SHOW;
          idx_d   = '0;
        end
        SHOW: if (tick) state_d = GUARD;
        GUARD: if (tick) begin
          state_d = SHOW;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Commit only uses the pre-edge pending flag, so a load accepted on a
  // boundary edge waits for the next boundary.
  assign accept = load_valid && !pending_valid_q;
  assign commit = pending_valid_q && (boundary || state_q == IDLE);

  always_comb begin
    pending_d       = accept ? load_data : pending_q;
    pending_valid_d = accept | (pending_valid_q & ~commit);
    active_d        = commit ? pending_q : active_q;
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_upper
      assign upper_zero[gi] = (active_d[VAL_W-1:4*gi] == '0);
    end
  endgenerate

  assign nib     = active_d[{idx_d, 2'b00} +: 4];
  assign blanked = blank_mask[idx_d] | (lzs_en & (idx_d != '0) & upper_zero[idx_d]);

  hex_decoder u_dec (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  // Outputs are registered from next-state values so they track the FSM edge.
  always_comb begin
    digit_sel_d  = '1;
    seg_d        = 7'b1111111;
    frame_done_d = boundary;
    if (state_d == SHOW) begin
      digit_sel_d[idx_d] = 1'b0;
      if (!blanked) seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      cnt_q           <= '0;
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      digit_sel_q     <= '1;
      seg_q           <= 7'b1111111;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      digit_sel_q     <= digit_sel_d;
      seg_q           <= seg_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign load_ready = ~pending_valid_q;
  assign digit_sel  = digit_sel_q;
  assign seg_out    = seg_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_hex_scan_controller.sv
// Bench for hex_scan_controller: table vectors, directed corner sequences and
// random stimulus against a timeline-arithmetic reference model.
module tb_hex_scan_controller;
  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = 2 * DIV * N;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        lzs_en = 1'b0;
  logic [3:0]  blank_mask = '0;
  logic        load_ready;
  logic [3:0]  digit_sel;
  logic [6:0]  seg_out;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hex_scan_controller #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .lzs_en     (lzs_en),
    .blank_mask (blank_mask),
    .digit_sel  (digit_sel),
    .seg_out    (seg_out),
    .frame_done (frame_done)
  );

  logic [6:0] seg_rom [16];
  int          run;
  logic        m_pv;
  logic [15:0] m_pend, m_act;

  typedef struct {
    logic [15:0]     value;
    logic            lz;
    logic [3:0]      msk;
    logic [3:0][6:0] segs;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Display position derived from how many consecutive enabled edges have elapsed.
  function automatic void expect_out(input int s, input logic [15:0] act, input logic lz,
                                     input logic [3:0] msk, output logic [3:0] ds,
                                     output logic [6:0] sg, output logic fd);
    int p, slot, d;
    logic [15:0] upper;
    ds = '1; sg = 7'h7F; fd = 1'b0;
    if (s >= DIV) begin
      p    = (s - DIV) % FRAME;
      slot = p / DIV;
      d    = slot / 2;
      if (slot % 2 == 0) begin
        ds[d] = 1'b0;
        upper = act >> (4 * d);
        if (!(msk[d] || (lz && d > 0 && upper == 16'h0))) sg = seg_rom[upper[3:0]];
      end
      fd = (s > DIV) && (p == 0);
    end
  endfunction

  task automatic step(input logic en, input logic lv, input logic [15:0] ld,
                      input logic lz, input logic [3:0] msk);
    logic was_idle, bnd, acc, com, efd;
    logic [3:0] eds;
    logic [6:0] esg;
    @(negedge clk);
    enable = en; load_valid = lv; load_data = ld; lzs_en = lz; blank_mask = msk;
    @(posedge clk);
    was_idle = (run < DIV);
    if (en) run++; else run = 0;
    bnd = en && run > DIV && ((run - DIV) % FRAME == 0);
    acc = lv && !m_pv;
    com = m_pv && (was_idle || bnd);
    if (com) begin m_act = m_pend; m_pv = 1'b0; end
    if (acc) begin m_pend = ld; m_pv = 1'b1; end
    #1;
    expect_out(run, m_act, lz, msk, eds, esg, efd);
    check("digit_sel", 32'(digit_sel), 32'(eds));
    check("seg_out", 32'(seg_out), 32'(esg));
    check("frame_done", 32'(frame_done), 32'(efd));
    check("load_ready", 32'(load_ready), 32'(!m_pv));
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; enable = 1'b0; load_valid = 1'b0;
    run = 0; m_pv = 1'b0; m_act = '0; m_pend = '0;
    #1;
    check("rst digit_sel", 32'(digit_sel), 32'hF);
    check("rst seg_out", 32'(seg_out), 32'h7F);
    check("rst frame_done", 32'(frame_done), 32'h0);
    check("rst load_ready", 32'(load_ready), 32'h1);
    @(posedge clk);
    #2 resetn = 1'b1;
  endtask

  initial begin
    logic lz_r;
    logic [3:0] msk_r;
    int pulses, last_pulse;
    seg_rom = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{16'h0000, 1'b0, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[1] = '{16'h0000, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[2] = '{16'h12AF, 1'b0, 4'b0000, {7'h79, 7'h24, 7'h08, 7'h0E}};
    vecs[3] = '{16'h0030, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h30, 7'h40}};
    vecs[4] = '{16'h0030, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h30, 7'h7F}};
    vecs[5] = '{16'h3210, 1'b0, 4'b0000, {7'h30, 7'h24, 7'h79, 7'h40}};
    vecs[6] = '{16'h7654, 1'b0, 4'b0000, {7'h78, 7'h02, 7'h12, 7'h19}};
    vecs[7] = '{16'hBA98, 1'b0, 4'b0000, {7'h03, 7'h08, 7'h10, 7'h00}};
    vecs[8] = '{16'hFEDC, 1'b0, 4'b0000, {7'h0E, 7'h06, 7'h21, 7'h46}};
    vecs[9] = '{16'h0A00, 1'b1, 4'b0100, {7'h7F, 7'h7F, 7'h40, 7'h40}};

    // Table: load in IDLE, then scan one full frame and check each digit.
    for (int v = 0; v < 10; v++) begin
      do_reset();
      if (vecs[v].value != 16'h0) begin
        step(1'b0, 1'b1, vecs[v].value, vecs[v].lz, vecs[v].msk);
        step(1'b0, 1'b0, 16'h0, vecs[v].lz, vecs[v].msk);
        check("idle commit load_ready", 32'(load_ready), 32'h1);
      end
      for (int c = 1; c <= DIV + FRAME; c++) begin
        step(1'b1, 1'b0, 16'h0, vecs[v].lz, vecs[v].msk);
        if (c >= DIV && (c - DIV) % (2 * DIV) == 0 && (c - DIV) < FRAME)
          check($sformatf("table%0d digit%0d seg", v, (c - DIV) / (2 * DIV)),
                32'(seg_out), 32'(vecs[v].segs[(c - DIV) / (2 * DIV)]));
      end
    end

    // Load during SHOW of digit 1: old frame completes, new value from the boundary.
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      step(1'b1, c == 13, 16'h12AF, 1'b0, 4'b0000);
      if (c == 13) check("load_ready drop", 32'(load_ready), 32'h0);
      if (c == 28) check("old frame digit3", 32'(seg_out), 32'h40);
      if (c == 36) check("boundary frame_done", 32'(frame_done), 32'h1);
      if (c == 36) check("new digit0", 32'(seg_out), 32'h0E);
      if (c == 44) check("new digit1", 32'(seg_out), 32'h08);
      if (c == 52) check("new digit2", 32'(seg_out), 32'h24);
      if (c == 60) check("new digit3", 32'(seg_out), 32'h79);
    end

    // Frame period: frame_done once every FRAME cycles.
    do_reset();
    pulses = 0; last_pulse = 0;
    for (int c = 1; c <= DIV + 4 * FRAME; c++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 4'b0000);
      if (frame_done) begin
        if (pulses > 0) check("frame period", 32'(c - last_pulse), 32'(FRAME));
        pulses++; last_pulse = c;
      end
    end
    check("frame pulse count", 32'(pulses), 32'h4);

    // Enable dropped mid-SHOW, then a load while IDLE commits on the next edge.
    do_reset();
    for (int c = 1; c <= 14; c++) step(1'b1, 1'b0, 16'h0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 16'h00C5, 1'b0, 4'b0000);
    check("disable digit_sel", 32'(digit_sel), 32'hF);
    check("disable seg_out", 32'(seg_out), 32'h7F);
    check("idle accept ready", 32'(load_ready), 32'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 4'b0000);
    check("idle commit ready", 32'(load_ready), 32'h1);
    for (int c = 1; c <= DIV; c++) step(1'b1, 1'b0, 16'h0, 1'b0, 4'b0000);
    check("idle commit digit0", 32'(seg_out), 32'h12);

    // Reset while a load is pending mid-frame discards it.
    do_reset();
    for (int c = 1; c <= 13; c++) step(1'b1, c == 13, 16'h5555, 1'b0, 4'b0000);
    do_reset();
    for (int c = 1; c <= DIV; c++) step(1'b1, 1'b0, 16'h0, 1'b0, 4'b0000);
    check("post-reset digit_sel", 32'(digit_sel), 32'hE);
    check("post-reset active", 32'(seg_out), 32'h40);

    // Random traffic against the reference model.
    do_reset();
    lz_r = 1'b0; msk_r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) lz_r = ~lz_r;
      msk_r = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) == 0, 16'($urandom), lz_r, msk_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
